bool_truth_table_sequencer: RTL and testbench



---
 rtl/bool_truth_table_sequencer_if.sv | 48 ++++
 rtl/bool_truth_table_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bool_truth_table_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bool_truth_table_sequencer_if.sv
// rtl/bool_truth_table_sequencer_if.sv - signal bundle between host/unit side and the truth-table sequencer
//
// Purpose: groups the host-side controls/results and the unit-side drive/sense
// signals of bool_truth_table_sequencer into one interface.
// Parameter: N_IN - number of unit inputs (rows = 2^N_IN).
// Signals:
//   start, abort, expected[2^N_IN]    host -> sequencer
//   busy, done, truth_table[2^N_IN],
//   pass, mismatch_idx[N_IN]          sequencer -> host
//   dut_in[N_IN]                      sequencer -> boolean unit
//   dut_y                             boolean unit -> sequencer
//   mismatch_cnt[N_IN+1]              sequencer -> host, only with MISMATCH_COUNT_EN
// Modports: slave = sequencer side, master = host/unit side.
interface bool_truth_table_sequencer_if #(
  parameter int N_IN = 2
);
  localparam int ROWS = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [ROWS-1:0] expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] truth_table;
  logic            pass;
  logic [N_IN-1:0] mismatch_idx;
`ifdef MISMATCH_COUNT_EN
  logic [N_IN:0]   mismatch_cnt;
`endif

  modport slave (
    input  start, abort, expected, dut_y,
    output dut_in, busy, done, truth_table, pass, mismatch_idx
`ifdef MISMATCH_COUNT_EN
    , output mismatch_cnt
`endif
  );

  modport master (
    output start, abort, expected, dut_y,
    input  dut_in, busy, done, truth_table, pass, mismatch_idx
`ifdef MISMATCH_COUNT_EN
    , input mismatch_cnt
`endif
  );
endinterface

// File: rtl/bool_truth_table_sequencer.sv
// rtl/bool_truth_table_sequencer.sv - sweeps a boolean unit over all input rows and checks its truth table
//
// Purpose: drives every input pattern 0..2^N_IN-1 onto a combinational unit,
// holds each pattern SETTLE cycles, samples the unit output into truth_table,
// and at the end compares against the expected table latched at start.
// Parameters: N_IN (1..6) unit inputs, SETTLE (1..15) hold cycles before sampling.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - bool_truth_table_sequencer_if.slave (start/abort/expected in,
//            busy/done/truth_table/pass/mismatch_idx out, dut_in out, dut_y in)
// Optional feature macro: MISMATCH_COUNT_EN adds bus.mismatch_cnt, the number
// of rows whose captured output differs from the expected table.
module bool_truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input logic                         clk,
  input logic                         rst_n,
  bool_truth_table_sequencer_if.slave bus
);
  localparam int            ROWS        = 1 << N_IN;
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN:0] LAST_ROW    = (N_IN + 1)'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N_IN:0]   row_q, row_d;
  logic [3:0]      settle_q, settle_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [ROWS-1:0] exp_q, exp_d;
  logic [ROWS-1:0] tt_q, tt_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] idx_q, idx_d;

  // Table as it would look with the current row captured; used both for the
  // SAMPLE write-back and for the verdict computed on the final row's edge.
  logic [ROWS-1:0] tt_capture;
  logic [ROWS-1:0] diff;
  logic [N_IN-1:0] first_diff;
`ifdef MISMATCH_COUNT_EN
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN:0]   diff_cnt;
`endif

  always_comb begin
    tt_capture                    = tt_q;
    tt_capture[row_q[N_IN-1:0]]   = bus.dut_y;
    diff                          = tt_capture ^ exp_q;
    // Scan downwards so the lowest differing row wins.
    first_diff = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = N_IN'(i);
    end
`ifdef MISMATCH_COUNT_EN
    diff_cnt = '0;
    for (int i = 0; i < ROWS; i++) begin
      diff_cnt = diff_cnt + {{N_IN{1'b0}}, diff[i]};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    dut_in_d = dut_in_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    pass_d   = pass_q;
    idx_d    = idx_q;
`ifdef MISMATCH_COUNT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_WAIT;
          exp_d    = bus.expected;
          tt_d     = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          dut_in_d = '0;
          row_d    = '0;
          settle_d = SETTLE_LOAD;
`ifdef MISMATCH_COUNT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_WAIT, S_SAMPLE: begin
        if (bus.abort) begin
          // Abort outranks the SAMPLE capture and discards the partial sweep.
          state_d  = S_IDLE;
          tt_d     = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          dut_in_d = '0;
          row_d    = '0;
          settle_d = '0;
`ifdef MISMATCH_COUNT_EN
          cnt_d    = '0;
`endif
        end else if (state_q == S_WAIT) begin
          if (settle_q == 4'd0) state_d = S_SAMPLE;
          else                  settle_d = settle_q - 4'd1;
        end else begin
          tt_d = tt_capture;
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
            pass_d  = (diff == '0);
            idx_d   = first_diff;
`ifdef MISMATCH_COUNT_EN
            cnt_d   = diff_cnt;
`endif
          end else begin
            state_d  = S_WAIT;
            row_d    = row_q + (N_IN + 1)'(1);
            dut_in_d = row_q[N_IN-1:0] + N_IN'(1);
            settle_d = SETTLE_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      settle_q <= '0;
      dut_in_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      pass_q   <= 1'b0;
      idx_q    <= '0;
`ifdef MISMATCH_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      dut_in_q <= dut_in_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      pass_q   <= pass_d;
      idx_q    <= idx_d;
`ifdef MISMATCH_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.dut_in       = dut_in_q;
  assign bus.busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.truth_table  = tt_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_idx = idx_q;
`ifdef MISMATCH_COUNT_EN
  assign bus.mismatch_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_bool_truth_table_sequencer.sv
// tb/tb_bool_truth_table_sequencer.sv - self-checking bench for bool_truth_table_sequencer
module tb_bool_truth_table_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] unit_a;
  logic       xor_p1, xor_p2;

  bool_truth_table_sequencer_if #(.N_IN(2)) bus_a ();
  bool_truth_table_sequencer_if #(.N_IN(2)) bus_b ();

  always #5 clk = ~clk;

  // Unit A: arbitrary 2-input function given as a lookup table.
  assign bus_a.dut_y = unit_a[bus_a.dut_in];

  // Unit B: XOR with two registered stages of delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_p1 <= 1'b0;
      xor_p2 <= 1'b0;
    end else begin
      xor_p1 <= ^bus_b.dut_in;
      xor_p2 <= xor_p1;
    end
  end
  assign bus_b.dut_y = xor_p2;

  bool_truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  bool_truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_first_diff(input logic [3:0] got, input logic [3:0] want);
    for (int i = 0; i < 4; i++) begin
      if (got[i] != want[i]) return i;
    end
    return 0;
  endfunction

  function automatic int ref_popcount(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  // Full sweep on unit A (SETTLE=1): each row occupies 2 cycles, done at E0+8.
  task automatic sweep_a(input logic [3:0] exp_tab, input bit disturb, input bit hold_start,
                         input string tag);
    bus_a.expected = exp_tab;
    bus_a.start    = 1'b1;
    tick();
    if (!hold_start) bus_a.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, ".dut_in"}, 32'(bus_a.dut_in), k / 2);
      check({tag, ".busy"}, 32'(bus_a.busy), 1);
      check({tag, ".done_early"}, 32'(bus_a.done), 0);
      if (disturb && k == 4) begin
        bus_a.start    = 1'b1;
        bus_a.expected = ~exp_tab;
      end
      if (disturb && k == 6) bus_a.start = 1'b0;
      tick();
    end
    check({tag, ".done"}, 32'(bus_a.done), 1);
    check({tag, ".busy_done"}, 32'(bus_a.busy), 0);
    check({tag, ".truth_table"}, 32'(bus_a.truth_table), 32'(unit_a));
    check({tag, ".pass"}, 32'(bus_a.pass), (unit_a == exp_tab) ? 1 : 0);
    check({tag, ".mismatch_idx"}, 32'(bus_a.mismatch_idx), ref_first_diff(unit_a, exp_tab));
`ifdef MISMATCH_COUNT_EN
    check({tag, ".mismatch_cnt"}, 32'(bus_a.mismatch_cnt), ref_popcount(unit_a ^ exp_tab));
`endif
    tick();
    check({tag, ".done_pulse"}, 32'(bus_a.done), 0);
    check({tag, ".idle"}, 32'(bus_a.busy), 0);
    check({tag, ".pass_held"}, 32'(bus_a.pass), (unit_a == exp_tab) ? 1 : 0);
  endtask

  initial begin
    logic [3:0] rexp;
    rst_n          = 1'b0;
    unit_a         = 4'b0000;
    bus_a.start    = 1'b0;
    bus_a.abort    = 1'b0;
    bus_a.expected = '0;
    bus_b.start    = 1'b0;
    bus_b.abort    = 1'b0;
    bus_b.expected = '0;
    tick();
    tick();
    check("reset.dut_in", 32'(bus_a.dut_in), 0);
    check("reset.busy", 32'(bus_a.busy), 0);
    check("reset.done", 32'(bus_a.done), 0);
    check("reset.truth_table", 32'(bus_a.truth_table), 0);
    check("reset.pass", 32'(bus_a.pass), 0);
    check("reset.mismatch_idx", 32'(bus_a.mismatch_idx), 0);
    check("reset_b.busy", 32'(bus_b.busy), 0);
    #2 rst_n = 1'b1;
    tick();

    // AND unit against its own table, then against OR.
    unit_a = 4'b1000;
    sweep_a(4'b1000, 1'b0, 1'b0, "and_pass");
    sweep_a(4'b1110, 1'b0, 1'b0, "and_vs_or");
    // Restart attempt and expected change mid-sweep must not disturb it.
    sweep_a(4'b1000, 1'b1, 1'b0, "disturb");

    // start held high through DONE: new sweep accepted at the first IDLE edge.
    sweep_a(4'b1000, 1'b0, 1'b1, "hold");
    tick();
    check("hold.restart_busy", 32'(bus_a.busy), 1);
    check("hold.restart_dut_in", 32'(bus_a.dut_in), 0);
    check("hold.restart_pass_clr", 32'(bus_a.pass), 0);
    check("hold.restart_tt_clr", 32'(bus_a.truth_table), 0);
    bus_a.start = 1'b0;
    repeat (8) tick();
    check("hold.done", 32'(bus_a.done), 1);
    check("hold.truth_table", 32'(bus_a.truth_table), 32'(unit_a));
    tick();

    // Abort in WAIT of row 2.
    unit_a         = 4'b0011;
    bus_a.expected = 4'b0011;
    bus_a.start    = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (4) tick();
    check("abort.pre_dut_in", 32'(bus_a.dut_in), 2);
    check("abort.pre_tt", 32'(bus_a.truth_table), 32'h3);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("abort.busy", 32'(bus_a.busy), 0);
    check("abort.dut_in", 32'(bus_a.dut_in), 0);
    check("abort.truth_table", 32'(bus_a.truth_table), 0);
    check("abort.pass", 32'(bus_a.pass), 0);
    for (int k = 0; k < 10; k++) begin
      check("abort.no_done", 32'(bus_a.done), 0);
      tick();
    end
    sweep_a(4'b0011, 1'b0, 1'b0, "after_abort");

    // Asynchronous reset during SAMPLE of row 1.
    unit_a      = 4'b0101;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (3) tick();
    check("arst.pre_dut_in", 32'(bus_a.dut_in), 1);
    check("arst.pre_tt", 32'(bus_a.truth_table), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(bus_a.busy), 0);
    check("arst.dut_in", 32'(bus_a.dut_in), 0);
    check("arst.truth_table", 32'(bus_a.truth_table), 0);
    check("arst.done", 32'(bus_a.done), 0);
    check("arst.pass", 32'(bus_a.pass), 0);
    #2 rst_n = 1'b1;
    tick();
    sweep_a(4'b0101, 1'b0, 1'b0, "after_arst");

    // Random functions and expected tables.
    for (int r = 0; r < 8; r++) begin
      unit_a = 4'($urandom);
      rexp   = ($urandom_range(0, 1) == 1) ? unit_a : 4'($urandom);
      sweep_a(rexp, 1'b0, 1'b0, "random");
    end

    // SETTLE=3 with a delayed XOR unit: 4 cycles per row, done at E0+16.
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      rexp           = (pass_no == 0) ? 4'b0110 : 4'($urandom);
      bus_b.expected = rexp;
      bus_b.start    = 1'b1;
      tick();
      bus_b.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
        check("xor.dut_in", 32'(bus_b.dut_in), k / 4);
        check("xor.no_done", 32'(bus_b.done), 0);
        tick();
      end
      check("xor.done", 32'(bus_b.done), 1);
      check("xor.truth_table", 32'(bus_b.truth_table), 32'h6);
      check("xor.pass", 32'(bus_b.pass), (rexp == 4'b0110) ? 1 : 0);
      check("xor.mismatch_idx", 32'(bus_b.mismatch_idx), ref_first_diff(4'b0110, rexp));
`ifdef MISMATCH_COUNT_EN
      check("xor.mismatch_cnt", 32'(bus_b.mismatch_cnt), ref_popcount(4'b0110 ^ rexp));
`endif
      tick();
      check("xor.done_pulse", 32'(bus_b.done), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
